mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the single-port unified memory between the multicycle CPU (fetch, lw and sw states of the main control FSM) and an I/O/DMA requester. Each requester gets a req/gnt/done handshake. CPU has fixed priority, with a bounded-starvation override for the I/O port. The block sits between the control/datapath memory-address mux and the memory macro, and it sequences the multi-cycle memory access.

Parameters:
DATA_W, 16, memory data width
ADDR_W, 16, memory address width
MEM_LAT, 1, memory read latency in cycles (1..7)
MAX_WAIT, 4, CPU grants tolerated while io_req is pending before I/O is forced through (1..15)

Ports:
CLK  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
cpu_req  in  1  CPU access request; held until cpu_done
cpu_we  in  1  1 = write (sw), 0 = read (fetch/lw)
cpu_adrs  in  ADDR_W  CPU address, stable while cpu_req
cpu_wdat  in  DATA_W  CPU write data
cpu_gnt  out  1  CPU currently owns memory
cpu_done  out  1  one-cycle completion pulse
cpu_rdat  out  DATA_W  read data, valid with cpu_done and held until the next CPU read completes
io_req, io_we, io_adrs, io_wdat  in  1/1/ADDR_W/DATA_W  I/O-port equivalents
io_gnt, io_done  out  1  I/O-port equivalents
io_rdat  out  DATA_W  I/O-port equivalent
mem_adrs  out  ADDR_W  memory address
mem_wdat  out  DATA_W  memory write data
mem_we  out  1  memory write strobe
mem_rdat  in  DATA_W  memory read data, valid MEM_LAT cycles after the address is presented

Behaviour:
- Reset: asynchronous, active-high. All outputs go to 0, state = IDLE, lat_cnt = 0, io_wait = 0. Reset asserted mid-access aborts the access with no done pulse, and mem_we drops immediately.
- States: IDLE, CPU_ACC, IO_ACC. All outputs are registered except the mem_* mux, which is combinational from state and the latched owner.
- IDLE arbitration at each rising edge:
  - Eligible requester: req = 1 and its own done is not high this cycle. This blocks a re-grant on a stale req.
  - Both eligible, io_wait < MAX_WAIT: CPU wins.
  - Both eligible, io_wait == MAX_WAIT: I/O wins.
  - One eligible: that requester wins.
  - None eligible: stay in IDLE.
- Grant: next state CPU_ACC or IO_ACC; the owner's gnt goes to 1 and lat_cnt is cleared.
- ACC states:
  - mem_adrs/mem_wdat follow the owner's inputs.
  - mem_we = owner_we during the first ACC cycle only (lat_cnt == 0).
  - lat_cnt increments each cycle.
- Leaving ACC, at the edge where lat_cnt == MEM_LAT (writes use the same length):
  - State returns to IDLE; gnt goes to 0 and the owner's done goes to 1 for exactly one cycle.
  - On a read, owner rdat captures mem_rdat. On a write, rdat is unchanged.
- Latency: req seen at edge k gives gnt in cycle k+1, and done in cycle k+MEM_LAT+2. Back-to-back accesses by the other requester start one cycle after done.
- io_wait:
  - Increments (saturating at MAX_WAIT) on every CPU grant issued while io_req = 1.
  - Clears on every I/O grant.
  - Is unaffected otherwise.
- IDLE outputs: mem_adrs = 0, mem_wdat = 0, mem_we = 0.
- Requester drops req mid-access (protocol violation): the access still completes and done still pulses.
- cpu_gnt and io_gnt are never 1 simultaneously.

Decomposition:
- Shared package: state encodings (IDLE=2'b00, CPU_ACC=2'b01, IO_ACC=2'b10), owner IDs OWN_CPU/OWN_IO, and default widths. The widths are reused by the main control and the memory wrapper.
- One natural sub-module: arb_wait_counter (saturating io_wait counter with inc/clr inputs and an at_max output).

Test Plan:
- CPU read only, MEM_LAT=1, mem[0x0010]=0xBEEF: cpu_req at edge 0 -> cpu_gnt in cycles 1-2, mem_we = 0, cpu_done in cycle 3, cpu_rdat = 0xBEEF; no regrant in cycle 3.
- CPU write 0x1234 to 0x0020: mem_we high in the first grant cycle only; a later read of 0x0020 returns 0x1234; cpu_rdat is unchanged by the write.
- Simultaneous requests, cpu_req held continuously, MAX_WAIT=4 -> CPU granted 4 times, then I/O granted on the 5th arbitration; io_wait returns to 0.
- I/O-only read while CPU idle: io_gnt next cycle, io_done after MEM_LAT+2 cycles; cpu_gnt stays 0 throughout.
- Reset asserted mid CPU_ACC with cpu_we = 1: mem_we, cpu_gnt, and cpu_done go to 0 asynchronously; after release, state is IDLE and a new request is served normally.
- MEM_LAT=3 sweep: done lands exactly 5 cycles after the request edge; gnt is never overlapping; the invariant cpu_gnt & io_gnt == 0 is checked by assertion.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the unified-memory port arbiter and its neighbours.
package mem_port_arbiter_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned LAT_W      = 3;   // holds MEM_LAT up to 7
  localparam int unsigned WAIT_W     = 4;   // holds MAX_WAIT up to 15

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    CPU_ACC = 2'b01,
    IO_ACC  = 2'b10
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_IO  = 1'b1
  } owner_e;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating count of CPU grants issued while the I/O port was waiting.
module arb_wait_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_max
);

  logic [WAIT_W-1:0] r_cnt;

  assign o_at_max = (r_cnt == WAIT_W'(MAX_WAIT));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !o_at_max) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between the CPU and the I/O/DMA requester.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_adrs,
  input  logic [DATA_W-1:0] cpu_wdat,
  output logic              cpu_gnt,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdat,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_adrs,
  input  logic [DATA_W-1:0] io_wdat,
  output logic              io_gnt,
  output logic              io_done,
  output logic [DATA_W-1:0] io_rdat,
  output logic [ADDR_W-1:0] mem_adrs,
  output logic [DATA_W-1:0] mem_wdat,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdat
);

  arb_state_e       r_state;
  owner_e           r_owner;
  logic [LAT_W-1:0] r_lat_cnt;

  logic w_cpu_elig;
  logic w_io_elig;
  logic w_io_at_max;
  logic w_grant_cpu;
  logic w_grant_io;
  logic w_last;

  // A requester whose done is high is still showing the req of the access just finished.
  assign w_cpu_elig  = cpu_req & ~cpu_done;
  assign w_io_elig   = io_req & ~io_done;
  assign w_grant_cpu = (r_state == IDLE) & w_cpu_elig & (~w_io_elig | ~w_io_at_max);
  assign w_grant_io  = (r_state == IDLE) & w_io_elig & ~w_grant_cpu;
  assign w_last      = (r_state != IDLE) & (r_lat_cnt == LAT_W'(MEM_LAT));

  arb_wait_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait (
    .i_clk    (CLK),
    .i_reset  (reset),
    .i_inc    (w_grant_cpu & io_req),
    .i_clr    (w_grant_io),
    .o_at_max (w_io_at_max)
  );

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_owner   <= OWN_CPU;
      r_lat_cnt <= '0;
      cpu_gnt   <= 1'b0;
      io_gnt    <= 1'b0;
      cpu_done  <= 1'b0;
      io_done   <= 1'b0;
      cpu_rdat  <= '0;
      io_rdat   <= '0;
    end else begin
      cpu_done <= 1'b0;
      io_done  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_lat_cnt <= '0;
          if (w_grant_cpu) begin
            r_state <= CPU_ACC;
            r_owner <= OWN_CPU;
            cpu_gnt <= 1'b1;
          end else if (w_grant_io) begin
            r_state <= IO_ACC;
            r_owner <= OWN_IO;
            io_gnt  <= 1'b1;
          end
        end
        CPU_ACC, IO_ACC: begin
          if (w_last) begin
            r_state <= IDLE;
            cpu_gnt <= 1'b0;
            io_gnt  <= 1'b0;
            if (r_owner == OWN_CPU) begin
              cpu_done <= 1'b1;
              if (!cpu_we) cpu_rdat <= mem_rdat;
            end else begin
              io_done <= 1'b1;
              if (!io_we) io_rdat <= mem_rdat;
            end
          end else begin
            r_lat_cnt <= r_lat_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // The write strobe is confined to the first access cycle; reads hold the address throughout.
  always_comb begin
    mem_adrs = '0;
    mem_wdat = '0;
    mem_we   = 1'b0;
    if (r_state != IDLE) begin
      if (r_owner == OWN_CPU) begin
        mem_adrs = cpu_adrs;
        mem_wdat = cpu_wdat;
        mem_we   = cpu_we & (r_lat_cnt == '0);
      end else begin
        mem_adrs = io_adrs;
        mem_wdat = io_wdat;
        mem_we   = io_we & (r_lat_cnt == '0);
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vectors, starvation and reset sequences, random vs. model.
module tb_mem_port_arbiter;

  localparam int unsigned DW   = 16;
  localparam int unsigned AW   = 16;
  localparam int unsigned LAT  = 1;
  localparam int unsigned MAXW = 4;

  logic CLK = 1'b0;
  logic reset;
  always #5 CLK = ~CLK;

  logic          cpu_req, cpu_we, io_req, io_we;
  logic [AW-1:0] cpu_adrs, io_adrs, mem_adrs;
  logic [DW-1:0] cpu_wdat, io_wdat, mem_wdat, mem_rdat, cpu_rdat, io_rdat;
  logic          cpu_gnt, cpu_done, io_gnt, io_done, mem_we;

  logic          l3_cpu_req, l3_io_req;
  logic [AW-1:0] l3_cpu_adrs, l3_io_adrs, l3_mem_adrs;
  logic [DW-1:0] l3_mem_wdat, l3_mem_rdat, l3_cpu_rdat, l3_io_rdat;
  logic          l3_cpu_gnt, l3_cpu_done, l3_io_gnt, l3_io_done, l3_mem_we;

  int n_chk = 0;
  int n_fail = 0;

  mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(LAT), .MAX_WAIT(MAXW)) u_dut (
    .CLK(CLK), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adrs(cpu_adrs), .cpu_wdat(cpu_wdat),
    .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdat(cpu_rdat),
    .io_req(io_req), .io_we(io_we), .io_adrs(io_adrs), .io_wdat(io_wdat),
    .io_gnt(io_gnt), .io_done(io_done), .io_rdat(io_rdat),
    .mem_adrs(mem_adrs), .mem_wdat(mem_wdat), .mem_we(mem_we), .mem_rdat(mem_rdat)
  );

  mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(3), .MAX_WAIT(MAXW)) u_dut3 (
    .CLK(CLK), .reset(reset),
    .cpu_req(l3_cpu_req), .cpu_we(1'b0), .cpu_adrs(l3_cpu_adrs), .cpu_wdat(16'h0),
    .cpu_gnt(l3_cpu_gnt), .cpu_done(l3_cpu_done), .cpu_rdat(l3_cpu_rdat),
    .io_req(l3_io_req), .io_we(1'b0), .io_adrs(l3_io_adrs), .io_wdat(16'h0),
    .io_gnt(l3_io_gnt), .io_done(l3_io_done), .io_rdat(l3_io_rdat),
    .mem_adrs(l3_mem_adrs), .mem_wdat(l3_mem_wdat), .mem_we(l3_mem_we), .mem_rdat(l3_mem_rdat)
  );

  assign l3_mem_rdat = 16'hA5A5 ^ l3_mem_adrs ^ l3_mem_wdat;

  function automatic logic [15:0] init_val(int a);
    if (a == 16) return 16'hBEEF;
    return 16'(a * 257) ^ 16'h5A00;
  endfunction

  // Memory macro: reloaded while reset is high, read data delayed by LAT cycles.
  logic [DW-1:0] mem [256];
  logic [DW-1:0] rd_pipe [LAT];
  always @(posedge CLK) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else if (mem_we) begin
      mem[mem_adrs[7:0]] <= mem_wdat;
    end
    rd_pipe[0] <= mem[mem_adrs[7:0]];
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdat = rd_pipe[LAT-1];

  always @(negedge CLK) begin
    if (!reset) begin
      n_chk++;
      if ((cpu_gnt & io_gnt) || (l3_cpu_gnt & l3_io_gnt)) begin
        n_fail++;
        $display("FAIL gnt_overlap: got cpu/io %0b%0b l3 %0b%0b, required never both 1",
                 cpu_gnt, io_gnt, l3_cpu_gnt, l3_io_gnt);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_adrs = '0; cpu_wdat = '0;
    io_req = 0; io_we = 0; io_adrs = '0; io_wdat = '0;
    l3_cpu_req = 0; l3_io_req = 0; l3_cpu_adrs = '0; l3_io_adrs = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    reset = 1'b0;
  endtask

  typedef struct {
    logic cr, cw; logic [15:0] ca, cd;
    logic ir; logic [15:0] ia;
    logic ecg, ecd, eig, eid, emw; logic [15:0] ecr, eir;
  } vec_t;

  function automatic vec_t mk(logic cr, logic cw, logic [15:0] ca, logic [15:0] cd, logic ir,
                              logic [15:0] ia, logic ecg, logic ecd, logic eig, logic eid,
                              logic emw, logic [15:0] ecr, logic [15:0] eir);
    vec_t v;
    v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd; v.ir = ir; v.ia = ia;
    v.ecg = ecg; v.ecd = ecd; v.eig = eig; v.eid = eid; v.emw = emw; v.ecr = ecr; v.eir = eir;
    return v;
  endfunction

  // Transaction-level reference model: owner, cycles left, wait tally, memory image.
  int            m_own, m_left, m_wait;
  bit            m_first, m_cd, m_id, m_rwe;
  logic          m_we;
  logic [15:0]   m_adr, m_wd, m_rval, m_cr, m_ir;
  logic [15:0]   m_mem [256];

  task automatic model_reset();
    m_own = 0; m_left = 0; m_wait = 0; m_first = 0; m_cd = 0; m_id = 0;
    m_we = 0; m_adr = '0; m_wd = '0; m_rval = '0; m_cr = '0; m_ir = '0; m_rwe = 0;
    for (int i = 0; i < 256; i++) m_mem[i] = init_val(i);
  endtask

  task automatic m_grant(int who, logic we, logic [15:0] adr, logic [15:0] wd);
    m_own = who; m_left = LAT; m_first = 1; m_we = we; m_adr = adr; m_wd = wd; m_rwe = we;
    if (we) m_mem[adr[7:0]] = wd;
    m_rval = m_mem[adr[7:0]];
  endtask

  task automatic model_step();
    bit ncd, nid, ce, ie;
    ncd = 0; nid = 0;
    if (m_own != 0) begin
      m_first = 0;
      if (m_left == 0) begin
        if (m_own == 1) begin ncd = 1; if (!m_rwe) m_cr = m_rval; end
        else begin nid = 1; if (!m_rwe) m_ir = m_rval; end
        m_own = 0;
      end else begin
        m_left--;
      end
    end else begin
      ce = cpu_req && !m_cd;
      ie = io_req && !m_id;
      if (ce && !(ie && m_wait == MAXW)) begin
        m_grant(1, cpu_we, cpu_adrs, cpu_wdat);
        if (io_req && m_wait < MAXW) m_wait++;
      end else if (ie) begin
        m_grant(2, io_we, io_adrs, io_wdat);
        m_wait = 0;
      end
    end
    m_cd = ncd;
    m_id = nid;
  endtask

  vec_t vecs[$];
  int   exp_cpu_g[$];
  int   exp_io_g[$];

  initial begin
    vecs.push_back(mk(1, 0, 16'h10, 0, 0, 0,          1, 0, 0, 0, 0, 16'h0,    16'h0));
    vecs.push_back(mk(1, 0, 16'h10, 0, 0, 0,          1, 0, 0, 0, 0, 16'h0,    16'h0));
    vecs.push_back(mk(1, 0, 16'h10, 0, 0, 0,          0, 1, 0, 0, 0, 16'hBEEF, 16'h0));
    vecs.push_back(mk(1, 0, 16'h10, 0, 0, 0,          0, 0, 0, 0, 0, 16'hBEEF, 16'h0));
    vecs.push_back(mk(1, 1, 16'h20, 16'h1234, 0, 0,   1, 0, 0, 0, 1, 16'hBEEF, 16'h0));
    vecs.push_back(mk(1, 1, 16'h20, 16'h1234, 0, 0,   1, 0, 0, 0, 0, 16'hBEEF, 16'h0));
    vecs.push_back(mk(1, 1, 16'h20, 16'h1234, 0, 0,   0, 1, 0, 0, 0, 16'hBEEF, 16'h0));
    vecs.push_back(mk(0, 0, 16'h0,  0, 0, 0,          0, 0, 0, 0, 0, 16'hBEEF, 16'h0));
    vecs.push_back(mk(1, 0, 16'h20, 0, 0, 0,          1, 0, 0, 0, 0, 16'hBEEF, 16'h0));
    vecs.push_back(mk(1, 0, 16'h20, 0, 0, 0,          1, 0, 0, 0, 0, 16'hBEEF, 16'h0));
    vecs.push_back(mk(1, 0, 16'h20, 0, 0, 0,          0, 1, 0, 0, 0, 16'h1234, 16'h0));
    vecs.push_back(mk(0, 0, 16'h0,  0, 0, 0,          0, 0, 0, 0, 0, 16'h1234, 16'h0));
    vecs.push_back(mk(0, 0, 16'h0,  0, 1, 16'h10,     0, 0, 1, 0, 0, 16'h1234, 16'h0));
    vecs.push_back(mk(0, 0, 16'h0,  0, 1, 16'h10,     0, 0, 1, 0, 0, 16'h1234, 16'h0));
    vecs.push_back(mk(0, 0, 16'h0,  0, 1, 16'h10,     0, 0, 0, 1, 0, 16'h1234, 16'hBEEF));
    vecs.push_back(mk(0, 0, 16'h0,  0, 0, 16'h0,      0, 0, 0, 0, 0, 16'h1234, 16'hBEEF));

    // Reset state
    reset = 1'b1;
    idle_inputs();
    #1;
    chk("reset cpu_gnt", cpu_gnt, 0);
    chk("reset io_gnt", io_gnt, 0);
    chk("reset cpu_done", cpu_done, 0);
    chk("reset io_done", io_done, 0);
    chk("reset cpu_rdat", cpu_rdat, 0);
    chk("reset io_rdat", io_rdat, 0);
    chk("reset mem_we", mem_we, 0);
    chk("reset mem_adrs", mem_adrs, 0);
    do_reset();

    // Directed table: one record per clock edge
    for (int i = 0; i < vecs.size(); i++) begin
      cpu_req = vecs[i].cr; cpu_we = vecs[i].cw; cpu_adrs = vecs[i].ca; cpu_wdat = vecs[i].cd;
      io_req = vecs[i].ir; io_adrs = vecs[i].ia;
      @(negedge CLK);
      chk($sformatf("vec%0d cpu_gnt", i), cpu_gnt, vecs[i].ecg);
      chk($sformatf("vec%0d cpu_done", i), cpu_done, vecs[i].ecd);
      chk($sformatf("vec%0d io_gnt", i), io_gnt, vecs[i].eig);
      chk($sformatf("vec%0d io_done", i), io_done, vecs[i].eid);
      chk($sformatf("vec%0d mem_we", i), mem_we, vecs[i].emw);
      chk($sformatf("vec%0d cpu_rdat", i), cpu_rdat, vecs[i].ecr);
      chk($sformatf("vec%0d io_rdat", i), io_rdat, vecs[i].eir);
    end

    // Starvation: CPU re-requests continuously; I/O is withheld only in cycles where cpu_done
    // is high, so it is always pending at a CPU grant and wins once MAX_WAIT is reached.
    do_reset();
    exp_cpu_g = '{0, 1, 4, 5, 8, 9, 12, 13, 19, 20, 23, 24};
    exp_io_g  = '{16, 17};
    for (int c = 0; c <= 24; c++) begin
      cpu_req = 1; cpu_we = 0; cpu_adrs = 16'h40;
      io_req = !(c inside {3, 7, 11, 15, 22}); io_we = 0; io_adrs = 16'h41;
      @(negedge CLK);
      chk($sformatf("starve c%0d cpu_gnt", c), cpu_gnt, (c inside {exp_cpu_g}) ? 1 : 0);
      chk($sformatf("starve c%0d io_gnt", c), io_gnt, (c inside {exp_io_g}) ? 1 : 0);
    end
    idle_inputs();

    // Reset during a CPU write: outputs drop without a clock edge and the write never lands.
    do_reset();
    cpu_req = 1; cpu_we = 1; cpu_adrs = 16'h30; cpu_wdat = 16'h5555;
    @(negedge CLK);
    chk("abort pre mem_we", mem_we, 1);
    chk("abort pre cpu_gnt", cpu_gnt, 1);
    #1 reset = 1'b1;
    #1;
    chk("abort mem_we", mem_we, 0);
    chk("abort cpu_gnt", cpu_gnt, 0);
    chk("abort cpu_done", cpu_done, 0);
    idle_inputs();
    @(negedge CLK);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk($sformatf("abort idle%0d cpu_done", c), cpu_done, 0);
      chk($sformatf("abort idle%0d cpu_gnt", c), cpu_gnt, 0);
    end
    cpu_req = 1; cpu_we = 0; cpu_adrs = 16'h30;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk($sformatf("abort read c%0d cpu_gnt", c), cpu_gnt, (c < 2) ? 1 : 0);
      chk($sformatf("abort read c%0d cpu_done", c), cpu_done, (c == 2) ? 1 : 0);
    end
    chk("abort read cpu_rdat", cpu_rdat, init_val(16'h30));
    idle_inputs();

    // Random traffic against the model
    do_reset();
    model_reset();
    for (int n = 0; n < 2500; n++) begin
      chk("rnd cpu_gnt", cpu_gnt, (m_own == 1) ? 1 : 0);
      chk("rnd io_gnt", io_gnt, (m_own == 2) ? 1 : 0);
      chk("rnd cpu_done", cpu_done, m_cd);
      chk("rnd io_done", io_done, m_id);
      chk("rnd cpu_rdat", cpu_rdat, m_cr);
      chk("rnd io_rdat", io_rdat, m_ir);
      chk("rnd mem_we", mem_we, (m_own != 0 && m_first && m_we) ? 1 : 0);
      chk("rnd mem_adrs", mem_adrs, (m_own != 0) ? m_adr : 16'h0);
      chk("rnd mem_wdat", mem_wdat, (m_own != 0) ? m_wd : 16'h0);
      if (!cpu_req || m_cd) begin
        if (m_cd) cpu_req = 0;
        if ($urandom_range(0, 2) == 0) begin
          cpu_req = 1; cpu_we = 1'($urandom_range(0, 1));
          cpu_adrs = {8'h00, 8'($urandom_range(0, 31))}; cpu_wdat = 16'($urandom);
        end
      end
      if (!io_req || m_id) begin
        if (m_id) io_req = 0;
        if ($urandom_range(0, 3) == 0) begin
          io_req = 1; io_we = 1'($urandom_range(0, 1));
          io_adrs = {8'h00, 8'($urandom_range(0, 31))}; io_wdat = 16'($urandom);
        end
      end
      model_step();
      @(negedge CLK);
    end
    idle_inputs();
    repeat (4) @(negedge CLK);

    // MEM_LAT = 3: CPU done exactly 5 cycles after the request edge, I/O follows right after
    l3_cpu_req = 1; l3_cpu_adrs = 16'h0001;
    l3_io_req = 1; l3_io_adrs = 16'h0002;
    for (int c = 0; c < 12; c++) begin
      if (c == 6) l3_cpu_req = 0;
      if (c == 10) l3_io_req = 0;
      @(negedge CLK);
      chk($sformatf("lat3 c%0d cpu_gnt", c), l3_cpu_gnt, (c <= 3) ? 1 : 0);
      chk($sformatf("lat3 c%0d cpu_done", c), l3_cpu_done, (c == 4) ? 1 : 0);
      chk($sformatf("lat3 c%0d io_gnt", c), l3_io_gnt, (c >= 5 && c <= 8) ? 1 : 0);
      chk($sformatf("lat3 c%0d io_done", c), l3_io_done, (c == 9) ? 1 : 0);
      chk($sformatf("lat3 c%0d mem_we", c), l3_mem_we, 0);
      if (c == 4) chk("lat3 cpu_rdat", l3_cpu_rdat, 16'hA5A4);
      if (c == 9) chk("lat3 io_rdat", l3_io_rdat, 16'hA5A7);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
